// File: rtl/mmp_iddmm_wacc.sv
// Word-serial multiply-accumulate carry stage: emits low word of prod+acc+carry per beat,
// keeps the high word as carry, and flushes the final carry as an extra word.
module mmp_iddmm_wacc #(
  parameter int unsigned WD     = 64,
  parameter int unsigned NWORDS = 64,
  parameter int unsigned CW     = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2*WD-1:0] prod_in,
  input  logic [WD-1:0]   acc_in,
  input  logic            in_valid,
  input  logic            in_first,
  input  logic            in_last,
  output logic            in_ready,
  output logic [WD-1:0]   out_word,
  output logic            out_valid,
  output logic            out_last,
  output logic [CW-1:0]   out_idx,
  output logic            busy,
  output logic            proto_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [WD-1:0]   carry_q, carry_d;
  logic [WD-1:0]   out_word_q, out_word_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [CW-1:0]   out_idx_q, out_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;

  logic            acc;
  logic            take;
  logic [2*WD-1:0] sum;
  logic [CW-1:0]   beat_idx;
  logic [CW-1:0]   next_cnt;

  always_comb begin
    acc      = in_valid & in_ready_q;
    // A beat is consumed in RUN, or in IDLE only when it opens an operand.
    take     = acc & ((state_q == RUN) | ((state_q == IDLE) & in_first));
    sum      = prod_in + {{WD{1'b0}}, acc_in} + {{WD{1'b0}}, (in_first ? '0 : carry_q)};
    beat_idx = in_first ? '0 : cnt_q;
    next_cnt = (beat_idx == CW'(NWORDS)) ? beat_idx : beat_idx + 1'b1;

    state_d     = state_q;
    carry_d     = carry_q;
    out_word_d  = out_word_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_idx_d   = out_idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (acc && !in_first) err_d = 1'b1;
      end
      RUN: begin
        if (acc && in_first) err_d = 1'b1;
      end
      FLUSH: begin
        out_word_d  = carry_q;
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        out_idx_d   = cnt_q;
        carry_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      out_valid_d = 1'b1;
      out_word_d  = sum[WD-1:0];
      carry_d     = sum[2*WD-1:WD];
      out_idx_d   = beat_idx;
      cnt_d       = next_cnt;
      if (in_last) begin
        state_d = FLUSH;
      end else if (next_cnt == CW'(NWORDS)) begin
        state_d = FLUSH;
        err_d   = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    in_ready_d = (state_d != FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = err_q;

endmodule
